sobol_idx_seq: RTL and testbench

Upstream sequencer for the Sobol generator stage. On `start` it emits a ready/valid stream of (path index, time-step dimension) pairs covering every path owned by this lane, with dimension as the inner loop. Each pair goes straight onto the Sobol stage's idx/dim inputs. Lanes interleave paths by striding NUM_LANES. Index 0 can be skipped, because it yields the all-zero Sobol point, which breaks the downstream inverse-normal mapping.

---
 rtl/fpga_cfg_pkg.sv | 19 +
 rtl/sobol_idx_seq.sv | 134 +++++++++++++
 tb/tb_sobol_idx_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared configuration for the Sobol path-generation pipeline: common widths,
// the dimension count, and the index sequencer's state encoding.
package fpga_cfg_pkg;

    localparam int FP_WIDTH = 32;
    localparam int SOBOL_M  = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } seq_state_t;

    // Width of a dimension counter; a single-dimension run still needs one bit.
    function automatic int dim_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sobol_idx_seq.sv
// Emits (path index, dimension) pairs for every path owned by this lane,
// dimension innermost, feeding the Sobol stage's idx/dim inputs.
module sobol_idx_seq
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int M         = SOBOL_M,
    parameter int NUM_LANES = 1,
    parameter int LANE_ID   = 0,
    parameter int SKIP_ZERO = 1,
    localparam int DW       = dim_w(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_num_paths,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] idx_out,
    output logic [DW-1:0]    dim_out,
    output logic             last_dim_out,
    output logic             last_out,
    output seq_state_t       state_dbg
);

    // Handshake: a pair transfers on every rising edge where valid_out && ready_in;
    // while valid_out is high and ready_in low, every pair output is held.

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH:0]   g_q;
    logic [WIDTH:0]   g_inc;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   cfg_ext;
    logic [WIDTH:0]   cfg_sum;
    logic             cfg_ovf;
    logic             cfg_empty;
    logic             first_last;
    logic             fire;
    logic             dim_end;
    logic [DW-1:0]    dim_inc;

    assign n_ext      = {1'b0, n_q};
    assign cfg_ext    = {1'b0, cfg_num_paths};
    assign cfg_sum    = cfg_ext + (WIDTH+1)'(SKIP_ZERO);
    assign cfg_ovf    = cfg_sum[WIDTH];
    assign cfg_empty  = (WIDTH+1)'(LANE_ID) >= cfg_ext;
    assign first_last = (M == 1) && ((WIDTH+1)'(LANE_ID + NUM_LANES) >= cfg_ext);
    assign g_inc      = g_q + (WIDTH+1)'(NUM_LANES);
    assign fire       = valid_out && ready_in;
    assign dim_end    = dim_out == DW'(M - 1);
    assign dim_inc    = dim_out + DW'(1);
    assign state_dbg  = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (cfg_ovf || cfg_empty) ? FIN : RUN;
            RUN:  if (fire && last_out) state_d = FIN;
            FIN:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            g_q          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            valid_out    <= 1'b0;
            idx_out      <= '0;
            dim_out      <= '0;
            last_dim_out <= 1'b0;
            last_out     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_q          <= cfg_num_paths;
                        cfg_err      <= cfg_ovf;
                        busy         <= 1'b1;
                        g_q          <= (WIDTH+1)'(LANE_ID);
                        idx_out      <= WIDTH'(LANE_ID + SKIP_ZERO);
                        dim_out      <= '0;
                        last_dim_out <= (M == 1);
                        last_out     <= first_last;
                        valid_out    <= !(cfg_ovf || cfg_empty);
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (last_out) begin
                            valid_out    <= 1'b0;
                            last_dim_out <= 1'b0;
                            last_out     <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else if (!dim_end) begin
                            dim_out      <= dim_inc;
                            last_dim_out <= dim_inc == DW'(M - 1);
                            last_out     <= (dim_inc == DW'(M - 1)) && (g_inc >= n_ext);
                        end else begin
                            // Next path of this lane: running adders, no multiply.
                            dim_out      <= '0;
                            g_q          <= g_inc;
                            idx_out      <= idx_out + WIDTH'(NUM_LANES);
                            last_dim_out <= (M == 1);
                            last_out     <= (M == 1) && ((g_inc + (WIDTH+1)'(NUM_LANES)) >= n_ext);
                        end
                    end
                end
                FIN: begin
                    // Entered without pairs: spend one cycle before the done pulse.
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_idx_seq.sv
// Bench for sobol_idx_seq: three lane configurations, an expected-pair queue
// built from nested path/dimension loops, and a per-cycle compare routine.
module tb_sobol_idx_seq;
    import fpga_cfg_pkg::*;

    localparam int NI = 3;
    localparam int P_M   [NI] = '{4, 2, 2};
    localparam int P_NL  [NI] = '{1, 4, 4};
    localparam int P_LID [NI] = '{0, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [NI];
    logic       start [NI];
    logic       ready [NI];
    logic [7:0] cfg   [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic       err   [NI];
    logic       valid [NI];
    logic       ldim  [NI];
    logic       lastp [NI];
    logic [7:0] idx   [NI];
    logic [7:0] dimv  [NI];
    seq_state_t st    [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int DW = dim_w(P_M[k]);
        logic [DW-1:0] d;
        sobol_idx_seq #(
            .WIDTH(8), .M(P_M[k]), .NUM_LANES(P_NL[k]), .LANE_ID(P_LID[k]), .SKIP_ZERO(1)
        ) u_dut (
            .clk(clk), .rst(rst[k]), .start(start[k]), .cfg_num_paths(cfg[k]),
            .busy(busy[k]), .done(done[k]), .cfg_err(err[k]),
            .valid_out(valid[k]), .ready_in(ready[k]),
            .idx_out(idx[k]), .dim_out(d), .last_dim_out(ldim[k]), .last_out(lastp[k]),
            .state_dbg(st[k])
        );
        assign dimv[k] = 8'(d);
    end

    logic [19:0] exp_q[$];
    logic        exp_err [NI];
    logic        pv [NI];
    logic        pr [NI];
    logic [19:0] pout [NI];
    logic        rnd_ready;
    int          total;
    int          bad;

    function automatic logic [19:0] pair_of(int k);
        return {2'(k), idx[k], dimv[k], ldim[k], lastp[k]};
    endfunction

    function automatic logic [31:0] outs_of(int k);
        return 32'({busy[k], done[k], err[k], valid[k], ldim[k], lastp[k], idx[k], dimv[k]});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Model: every owned path g = LANE_ID, LANE_ID+NL, ... below n, all dims in order.
    task automatic build(int k, int n);
        exp_err[k] = (n + 1) > 255;
        if (!exp_err[k])
            for (int g = P_LID[k]; g < n; g += P_NL[k])
                for (int dd = 0; dd < P_M[k]; dd++)
                    exp_q.push_back({2'(k), 8'(g + 1), 8'(dd), dd == P_M[k] - 1,
                                     (dd == P_M[k] - 1) && (g + P_NL[k] >= n)});
    endtask

    task automatic compare();
        logic [19:0] e;
        for (int k = 0; k < NI; k++) begin
            if (rst[k]) begin
                pv[k] = 1'b0;
            end else begin
                if (pv[k] && !pr[k]) begin
                    total++;
                    if (!valid[k] || pair_of(k) !== pout[k]) begin
                        bad++;
                        $display("FAIL stall[%0d]: got v=%0b %h expected v=1 %h", k, valid[k], pair_of(k), pout[k]);
                    end
                end
                if (valid[k] && ready[k]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_pair[%0d]: got %h expected none", k, pair_of(k));
                    end else begin
                        e = exp_q.pop_front();
                        if (pair_of(k) !== e) begin
                            bad++;
                            $display("FAIL pair[%0d]: got %h expected %h", k, pair_of(k), e);
                        end
                    end
                end
                if (done[k]) begin
                    total++;
                    if (exp_q.size() != 0 || busy[k] || err[k] !== exp_err[k]) begin
                        bad++;
                        $display("FAIL done[%0d]: got left=%0d busy=%0b err=%0b expected left=0 busy=0 err=%0b",
                                 k, exp_q.size(), busy[k], err[k], exp_err[k]);
                    end
                end
                pv[k]   = valid[k];
                pr[k]   = ready[k];
                pout[k] = pair_of(k);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        if (rnd_ready)
            for (int k = 0; k < NI; k++) ready[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start(int k, int n);
        cfg[k]   = 8'(n);
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int bound, output int cyc);
        cyc = 0;
        while (!done[k]) begin
            if (cyc >= bound) begin
                total++;
                bad++;
                $display("FAIL timeout[%0d]: got no done after %0d cycles expected done", k, cyc);
                break;
            end
            step();
            cyc++;
        end
    endtask

    int  c;
    int  n;
    int  kk;
    logic saw;

    initial begin
        total = 0;
        bad = 0;
        rnd_ready = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; ready[k] = 1'b1; cfg[k] = '0;
            exp_err[k] = 1'b0; pv[k] = 1'b0; pr[k] = 1'b0; pout[k] = '0;
        end
        repeat (3) step();
        for (int k = 0; k < NI; k++) begin
            chk("reset_outs", outs_of(k), 32'd0);
            chk("reset_state", 32'(st[k]), 32'(IDLE));
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        step();

        // Basic run, model pinned by hand-computed entries.
        build(0, 3);
        chk("model_len", 32'(exp_q.size()), 32'd12);
        chk("model_first", 32'(exp_q[0]), 32'h00400);
        chk("model_last", 32'(exp_q[11]), 32'h00C0F);
        pulse_start(0, 3);
        chk("first_valid", 32'({valid[0], busy[0]}), 32'd3);
        wait_done(0, 50, c);
        chk("basic_done_lat", 32'(c), 32'd12);
        chk("basic_err", 32'(err[0]), 32'd0);
        step();

        // Backpressure with random ready and random run sizes.
        rnd_ready = 1'b1;
        for (int rep = 0; rep < 6; rep++) begin
            kk = (rep == 0) ? 0 : $urandom_range(0, NI - 1);
            n  = (rep == 0) ? 3 : $urandom_range(1, 9);
            build(kk, n);
            pulse_start(kk, n);
            wait_done(kk, 400, c);
            step();
        end
        rnd_ready = 1'b0;
        for (int k = 0; k < NI; k++) ready[k] = 1'b1;
        step();

        // Lane striding.
        build(1, 10);
        chk("lane2_len", 32'(exp_q.size()), 32'd4);
        chk("lane2_idx", 32'(exp_q[2][17:10]), 32'd7);
        pulse_start(1, 10);
        wait_done(1, 50, c);
        step();
        build(2, 10);
        chk("lane3_idx", 32'(exp_q[0][17:10]), 32'd4);
        pulse_start(2, 10);
        wait_done(2, 50, c);
        step();
        build(1, 2);
        pulse_start(1, 2);
        chk("lane_empty_valid", 32'(valid[1]), 32'd0);
        wait_done(1, 10, c);
        chk("lane_empty_lat", 32'(c), 32'd1);
        step();

        // Degenerate and error cases.
        build(0, 0);
        pulse_start(0, 0);
        wait_done(0, 10, c);
        chk("n0_lat", 32'(c), 32'd1);
        chk("n0_err", 32'(err[0]), 32'd0);
        step();
        build(0, 255);
        pulse_start(0, 255);
        chk("ovf_err", 32'({err[0], valid[0]}), 32'd2);
        wait_done(0, 10, c);
        chk("ovf_lat", 32'(c), 32'd1);
        step();
        build(0, 1);
        pulse_start(0, 1);
        chk("err_cleared", 32'(err[0]), 32'd0);
        wait_done(0, 20, c);
        step();

        // Reset after five pairs.
        build(0, 5);
        pulse_start(0, 5);
        repeat (5) step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        exp_q.delete();
        exp_err[0] = 1'b0;
        chk("midrst_outs", outs_of(0), 32'd0);
        chk("midrst_state", 32'(st[0]), 32'(IDLE));
        saw = 1'b0;
        repeat (4) begin
            step();
            saw = saw | done[0];
        end
        chk("midrst_no_done", 32'(saw), 32'd0);
        build(0, 2);
        pulse_start(0, 2);
        chk("restart_first", 32'({valid[0], idx[0], dimv[0]}), 32'h10100);
        wait_done(0, 30, c);
        step();

        // Start while busy, then start in the done cycle.
        build(0, 2);
        pulse_start(0, 2);
        repeat (2) step();
        pulse_start(0, 6);
        wait_done(0, 30, c);
        chk("busy_start_lat", 32'(c), 32'd5);
        cfg[0]   = 8'd4;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("done_start_ign", 32'({valid[0], busy[0]}), 32'd0);
        repeat (4) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
